// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter:
// FSM encodings, default cell range and port ids.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic [63:0] MEM_LO_DEF = 64'd1;
    localparam logic [63:0] MEM_HI_DEF = 64'd20;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    // Full-width inclusive range compare; no truncation of the address.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] lo,
                                           input logic [63:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory-port signals for mem_port_arbiter.
// slave: arbiter view. master: environment (requesters + memory) view.
interface mem_port_arbiter_if #(
    parameter int DW = 64,
    parameter int AW = 64
);
    logic          p0_req;
    logic          p0_wr;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ack;

    logic          p1_req;
    logic          p1_wr;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ack;

    logic [DW-1:0] rdata;
    logic          err;
    logic          busy;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_valM;

    modport slave (
        input  p0_req, p0_wr, p0_addr, p0_wdata,
        input  p1_req, p1_wr, p1_addr, p1_wdata,
        input  mem_valM,
        output p0_ack, p1_ack, rdata, err, busy,
        output mem_addr, mem_data, mem_read, mem_write
    );

    modport master (
        output p0_req, p0_wr, p0_addr, p0_wdata,
        output p1_req, p1_wr, p1_addr, p1_wdata,
        output mem_valM,
        input  p0_ack, p1_ack, rdata, err, busy,
        input  mem_addr, mem_data, mem_read, mem_write
    );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: prio port wins a tie,
// otherwise the single requester wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       valid,
    output logic       winner
);
    assign valid  = |req;
    assign winner = (&req) ? prio : (req[1] ? PORT_LDR : PORT_CPU);
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the shared data-memory port.
// IDLE -> ACCESS -> RESP, round-robin grant.
// Optional address bounds check: define MEM_ARB_BOUNDS_CHECK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int            DW     = 64,
    parameter int            AW     = 64,
    parameter logic [63:0]   MEM_LO = MEM_LO_DEF,
    parameter logic [63:0]   MEM_HI = MEM_HI_DEF
)(
    input logic               clk,
    input logic               res,
    mem_port_arbiter_if.slave bus
);
    arb_state_t    state;
    logic          prio;
    logic          lat_id;
    logic          lat_wr;
    logic          lat_oor;
    logic          ack0, ack1, err_q, busy_q;
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mdata;
    logic          mrd, mwr;

    logic          valid, winner;
    logic          sel_wr, sel_oor;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_pick2 u_pick (
        .req    ({bus.p1_req, bus.p0_req}),
        .prio   (prio),
        .valid  (valid),
        .winner (winner)
    );

    assign sel_wr    = winner ? bus.p1_wr    : bus.p0_wr;
    assign sel_addr  = winner ? bus.p1_addr  : bus.p0_addr;
    assign sel_wdata = winner ? bus.p1_wdata : bus.p0_wdata;

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    assign sel_oor = !addr_in_range(64'(sel_addr), MEM_LO, MEM_HI);
`else
    assign sel_oor = 1'b0;
`endif

    // Sequencer: latch winner in IDLE, drive memory in ACCESS, ack in RESP.
    // Memory-side registers are loaded on grant so they are valid for the
    // whole ACCESS cycle and cleared (address parked at 0) on leaving it.
    always_ff @(posedge clk) begin
        if (res) begin
            state   <= IDLE;
            prio    <= PORT_CPU;
            lat_id  <= PORT_CPU;
            lat_wr  <= 1'b0;
            lat_oor <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            maddr   <= '0;
            mdata   <= '0;
            mrd     <= 1'b0;
            mwr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        state   <= ACCESS;
                        lat_id  <= winner;
                        lat_wr  <= sel_wr;
                        lat_oor <= sel_oor;
                        prio    <= ~winner;
                        busy_q  <= 1'b1;
                        maddr   <= sel_oor ? '0 : sel_addr;
                        mdata   <= sel_oor ? '0 : sel_wdata;
                        mrd     <= !sel_oor && !sel_wr;
                        mwr     <= !sel_oor && sel_wr;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    maddr <= '0;
                    mdata <= '0;
                    mrd   <= 1'b0;
                    mwr   <= 1'b0;
                    if (lat_oor)
                        rdata_q <= '0;
                    else if (!lat_wr)
                        rdata_q <= bus.mem_valM;
                    ack0  <= (lat_id == PORT_CPU);
                    ack1  <= (lat_id == PORT_LDR);
                    err_q <= lat_oor;
                end
                RESP: begin
                    state  <= IDLE;
                    ack0   <= 1'b0;
                    ack1   <= 1'b0;
                    err_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset gates the memory side immediately so a reset in ACCESS never writes.
    assign bus.mem_addr  = res ? '0 : maddr;
    assign bus.mem_data  = res ? '0 : mdata;
    assign bus.mem_read  = mrd && !res;
    assign bus.mem_write = mwr && !res;

    assign bus.p0_ack = ack0;
    assign bus.p1_ack = ack1;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
endmodule
